// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential RV32M divider: op encoding and FSM states.
// Also the helpers that decode signedness and quotient/remainder select from an op.
package div_pkg;

    localparam int DIV_OP_W = 2;

    typedef enum logic [DIV_OP_W-1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

    // Bit 0 clear marks the signed flavours (DIV/REM); bit 1 set selects the remainder.
    function automatic logic op_is_signed(div_op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(div_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle between the EX-stage M unit (master) and the divider (slave).
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    import div_pkg::*;

    logic                start;
    logic [DIV_OP_W-1:0] op;
    logic [WIDTH-1:0]    dividend;
    logic [WIDTH-1:0]    divisor;
    logic                flush;
    logic                ready;
    logic                done;
    logic [WIDTH-1:0]    result;

    modport master (
        output start, op, dividend, divisor, flush,
        input  ready, done, result
    );

    modport slave (
        input  start, op, dividend, divisor, flush,
        output ready, done, result
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
// The WIDTH+1 bit subtract lives here so a radix-4 step can replace it later.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_i};
        // Borrow out of the top bit means the divisor did not fit: keep the shifted value.
        rem_o   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define SEQ_DIVIDER_FAST_SPECIAL_EN to finish divide-by-zero, overflow and |a|<|b| in one cycle.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_divider_if.slave    bus
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q;
    div_op_e          op_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             div_zero_q;
    logic             ovf_q;
    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;

    div_op_e          in_op;
    logic             in_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             in_div_zero;
    logic             in_ovf;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] result_d;
    logic             fast_hit;
    logic [WIDTH-1:0] fast_result;

    always_comb begin
        in_op       = div_op_e'(bus.op);
        in_signed   = op_is_signed(in_op);
        a_neg       = in_signed & bus.dividend[WIDTH-1];
        b_neg       = in_signed & bus.divisor[WIDTH-1];
        abs_a       = a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
        abs_b       = b_neg ? (~bus.divisor + 1'b1) : bus.divisor;
        in_div_zero = (bus.divisor == '0);
        in_ovf      = in_signed && (bus.dividend == MIN_VAL) && (bus.divisor == '1);
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (rem_step),
        .quo_o     (quo_step)
    );

    // Sign correction plus the architecturally defined corner-case results.
    always_comb begin
        quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        if (div_zero_q) begin
            quo_fix = '1;
            rem_fix = dividend_q;
        end else if (ovf_q) begin
            quo_fix = MIN_VAL;
            rem_fix = '0;
        end
        result_d = op_is_rem(op_q) ? rem_fix : quo_fix;
    end

`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
    always_comb begin
        fast_hit    = in_div_zero || in_ovf || (abs_a < abs_b);
        fast_result = op_is_rem(in_op) ? bus.dividend : '0;
        if (in_div_zero) begin
            fast_result = op_is_rem(in_op) ? bus.dividend : '1;
        end else if (in_ovf) begin
            fast_result = op_is_rem(in_op) ? '0 : MIN_VAL;
        end
    end
`else
    always_comb begin
        fast_hit    = 1'b0;
        fast_result = '0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= DIV;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q       <= in_op;
                        dividend_q <= bus.dividend;
                        divisor_q  <= abs_b;
                        quo_q      <= abs_a;
                        rem_q      <= '0;
                        cnt_q      <= CNT_W'(WIDTH - 1);
                        neg_quo_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        div_zero_q <= in_div_zero;
                        ovf_q      <= in_ovf;
                        ready_q    <= 1'b0;
                        if (fast_hit) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= fast_result;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    state_q  <= DONE;
                    done_q   <= 1'b1;
                    result_q <= result_d;
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed RV32M corner cases, random ops against an
// arithmetic reference, flush, asynchronous reset and back-to-back issue timing.
module tb_seq_divider;

    localparam int W = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;
`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion before 2ms");
        $fatal(1, "watchdog");
    end

    // Reference: RISC-V M-extension division semantics from plain arithmetic.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        bit          sg;
        sg = (op == 2'b00) || (op == 2'b10);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sg && a == MINV && b == 32'hFFFF_FFFF) begin
            q = MINV;
            r = 32'd0;
        end else if (sg) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return (op == 2'b10 || op == 2'b11) ? r : q;
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint ma;
        longint mb;
        bit     sg;
        bit     fast;
        sg = (op == 2'b00) || (op == 2'b10);
        if (sg) begin
            ma = $signed(a);
            mb = $signed(b);
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
        end else begin
            ma = a;
            mb = b;
        end
        fast = (b == 32'd0) || (sg && a == MINV && b == 32'hFFFF_FFFF) || (ma < mb);
        return (fast && FAST_EN) ? 1 : W + 2;
    endfunction

    // Issue one op, return the result seen with done, the latency in cycles from the
    // accept edge (accept edge itself counts as 1) and how often ready was high while busy.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int rdy_hi);
        int w;
        w = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.op       = 2'($urandom);
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        lat    = 1;
        rdy_hi = 0;
        res    = 32'hDEAD_BEEF;
        while (1) begin
            @(negedge clk);
            if (bus.ready !== 1'b0) rdy_hi++;
            if (bus.done === 1'b1) begin
                res = bus.result;
                break;
            end
            if (lat >= 100) begin
                lat = -1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        bus.op       = 2'b00;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;
        #23;
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
            errors++;
            $display("FAIL reset: ready=%b done=%b result=%h, required ready=1 done=0 result=0",
                     bus.ready, bus.done, bus.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset: ready=%b done=%b result=%h", bus.ready, bus.done, bus.result);
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [13];
        logic [31:0] t_a  [13];
        logic [31:0] t_b  [13];
        logic [31:0] t_e  [13];
        logic [31:0] res;
        int          lat;
        int          rdy;
        t_op = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10,
                 2'b01, 2'b11, 2'b01, 2'b10};
        t_a  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'd5, MINV, MINV,
                 32'd3, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        t_b  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'd7, 32'd7, 32'd1, 32'hFFFF_FFF9};
        t_e  = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd5, MINV, 32'd0,
                 32'd0, 32'd3, 32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 13; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], res, lat, rdy);
            $display("directed %0d: op=%0d a=%h b=%h result=%h lat=%0d", i, t_op[i], t_a[i], t_b[i], res, lat);
            checks++;
            if (res !== t_e[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got %h, required %h", i, res, t_e[i]);
            end
            checks++;
            if (lat != exp_lat(t_op[i], t_a[i], t_b[i])) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, exp_lat(t_op[i], t_a[i], t_b[i]));
            end
            checks++;
            if (rdy != 0) begin
                errors++;
                $display("FAIL directed_busy_ready[%0d]: ready high in %0d busy cycles, required 0", i, rdy);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          rdy;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = MINV; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: begin b = $urandom; a = 32'($urandom_range(0, 50)); end
                4: b = -32'($urandom_range(1, 20));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_op(op, a, b, res, lat, rdy);
            $display("random %0d: op=%0d a=%h b=%h result=%h lat=%0d", i, op, a, b, res, lat);
            checks++;
            if (res !== model(op, a, b) || lat != exp_lat(op, a, b)) begin
                errors++;
                $display("FAIL random[%0d]: result=%h lat=%0d, required result=%h lat=%0d",
                         i, res, lat, model(op, a, b), exp_lat(op, a, b));
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          lat;
        int          rdy;
        int          seen_done;
        do_op(2'b01, 32'd20, 32'd6, res, lat, rdy);
        checks++;
        if (res !== 32'd3) begin
            errors++;
            $display("FAIL flush_setup: got %h, required 00000003", res);
        end
        @(negedge clk);
        bus.op = 2'b01; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        seen_done = 0;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done++;
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        if (bus.done === 1'b1) seen_done++;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        if (bus.done === 1'b1) seen_done++;
        $display("flush: ready=%b done_pulses=%0d result=%h", bus.ready, seen_done, bus.result);
        checks++;
        if (bus.ready !== 1'b1 || seen_done != 0 || bus.result !== 32'd3) begin
            errors++;
            $display("FAIL flush_abort: ready=%b done_pulses=%0d result=%h, required ready=1 done_pulses=0 result=00000003",
                     bus.ready, seen_done, bus.result);
        end
        do_op(2'b01, 32'd50, 32'd5, res, lat, rdy);
        $display("flush_restart: result=%h lat=%0d", res, lat);
        checks++;
        if (res !== 32'd10 || lat != W + 2) begin
            errors++;
            $display("FAIL flush_restart: result=%h lat=%0d, required result=0000000a lat=%0d", res, lat, W + 2);
        end
        // start together with flush in IDLE must not be accepted
        @(negedge clk);
        bus.op = 2'b01; bus.dividend = 32'd5; bus.divisor = 32'd0; bus.start = 1'b1; bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        $display("flush_with_start: ready=%b done=%b result=%h", bus.ready, bus.done, bus.result);
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.result !== 32'd10) begin
            errors++;
            $display("FAIL flush_with_start: ready=%b done=%b result=%h, required ready=1 done=0 result=0000000a",
                     bus.ready, bus.done, bus.result);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int          lat;
        int          rdy;
        @(negedge clk);
        bus.op = 2'b01; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k < 20; k++) begin
            @(posedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        $display("async_reset: ready=%b done=%b result=%h", bus.ready, bus.done, bus.result);
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.result !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: ready=%b done=%b result=%h, required ready=1 done=0 result=0",
                     bus.ready, bus.done, bus.result);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(2'b01, 32'd9, 32'd3, res, lat, rdy);
        $display("after_reset: result=%h lat=%0d", res, lat);
        checks++;
        if (res !== 32'd3 || lat != W + 2) begin
            errors++;
            $display("FAIL after_reset: result=%h lat=%0d, required result=00000003 lat=%0d", res, lat, W + 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  b_op  [3];
        logic [31:0] b_a   [3];
        logic [31:0] b_b   [3];
        int          acc   [3];
        int          dn    [3];
        logic [31:0] dres  [3];
        int          n_acc;
        int          n_dn;
        for (int i = 0; i < 3; i++) begin
            b_op[i] = {1'($urandom), 1'b1};
            b_a[i]  = $urandom | 32'h4000_0000;
            b_b[i]  = 32'($urandom_range(1, 1000));
            acc[i]  = -1;
            dn[i]   = -1;
            dres[i] = 32'd0;
        end
        n_acc = 0;
        n_dn  = 0;
        bus.start = 1'b1;
        for (int cyc = 0; cyc < 3 * (W + 3) + 4; cyc++) begin
            if (bus.ready === 1'b1 && n_acc < 3) begin
                acc[n_acc]   = cyc;
                bus.op       = b_op[n_acc];
                bus.dividend = b_a[n_acc];
                bus.divisor  = b_b[n_acc];
                n_acc++;
            end else if (bus.ready === 1'b1) begin
                bus.start = 1'b0;
            end else begin
                bus.op       = 2'($urandom);
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
            end
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (n_dn < 3) begin
                    dn[n_dn]   = cyc;
                    dres[n_dn] = bus.result;
                end
                n_dn++;
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        checks++;
        if (n_dn != 3) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d done pulses, required 3", n_dn);
        end
        for (int i = 0; i < 3; i++) begin
            $display("b2b %0d: op=%0d a=%h b=%h accept=%0d done=%0d result=%h",
                     i, b_op[i], b_a[i], b_b[i], acc[i], dn[i], dres[i]);
            checks++;
            if (acc[i] != i * (W + 3) || dn[i] != i * (W + 3) + W + 2) begin
                errors++;
                $display("FAIL b2b_timing[%0d]: accept=%0d done=%0d, required accept=%0d done=%0d",
                         i, acc[i], dn[i], i * (W + 3), i * (W + 3) + W + 2);
            end
            checks++;
            if (dres[i] !== model(b_op[i], b_a[i], b_b[i])) begin
                errors++;
                $display("FAIL b2b_result[%0d]: got %h, required %h", i, dres[i], model(b_op[i], b_a[i], b_b[i]));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 restoring divider implementing the RV32M DIV, DIVU, REM and REMU ops.
- Complements the combinational Wallace-tree multiplier: the multiplier is single-pass, while division runs one quotient bit per cycle.
- Sits in the EX-stage M-extension unit; the pipeline stalls on `ready`=0 until `done`.
- Results match the RISC-V spec exactly, including divide-by-zero and signed overflow.

Parameters:
WIDTH, 32, operand/result width in bits (must be ≥4)
CNT_W, $clog2(WIDTH), iteration counter width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when ready=1
op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
dividend  input  WIDTH  rs1 value, sampled on accept
divisor  input  WIDTH  rs2 value, sampled on accept
flush  input  1  abort current op (pipeline kill)
ready  output  1  high in IDLE only
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  quotient or remainder per op; held until next accept

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready=1, done=0, result=0, counter=0, internal registers cleared. Reset mid-operation discards the op with no done pulse.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE: on start & ~flush, latch op and operands.
  - Signed ops (DIV/REM) take the absolute values of both operands and record neg_q = sign(a)^sign(b) and neg_r = sign(a).
  - Load counter=WIDTH-1 and rem=0, then go to CALC.
- CALC: each cycle, shift {rem,quo} left by 1.
  - trial = rem_shifted - divisor_abs, computed at WIDTH+1 bits.
  - If trial is non-negative: rem=trial and quo[0]=1. Otherwise restore, with quo[0]=0.
  - When counter==0, go to FIX; otherwise decrement the counter. CALC lasts exactly WIDTH cycles.
- FIX: apply the negations (two's complement) for signed ops and select quotient or remainder into result. Then go to DONE.
- Special cases, resolved in FIX:
  - divisor==0: quotient = all ones; remainder = dividend.
  - DIV/REM with dividend=MIN and divisor=-1: quotient = MIN; remainder = 0.
- DONE: done=1 for exactly one cycle, ready=0. Next state is IDLE.
- Latency: done is high WIDTH+2 cycles after the accept edge (34 for WIDTH=32). The next start is accepted in the cycle after done, so back-to-back issue runs every WIDTH+3 cycles.
- start while ready=0 is ignored (no queuing).
- flush in any state: next state is IDLE, no done pulse, result keeps its previous value. flush together with start in IDLE means start is not accepted.
- result changes only on the FIX->DONE edge.

Optional Feature:
- Macro: SEQ_DIVIDER_FAST_SPECIAL_EN.
- When defined:
  - IDLE detects divisor==0 and the signed overflow case on accept, loads result directly and goes IDLE -> DONE. done is high 1 cycle after accept.
  - Operands with dividend < divisor (unsigned, or by magnitude for signed ops) also skip CALC: quotient=0, remainder=dividend. This path also finishes 1 cycle after accept.
- When undefined: every op takes the full WIDTH+2 latency. Result values are identical either way.

Decomposition:
- Package `div_pkg`:
  - `div_op_e` enum (DIV, DIVU, REM, REMU).
  - `div_state_e` enum (IDLE, CALC, FIX, DONE).
  - `DIV_OP_W`=2.
- One sub-module, `div_step`: a combinational single restoring iteration.
  - Inputs: rem, quo, divisor. Outputs: next rem and next quo.
  - Keeps the WIDTH+1 subtract isolated for the later radix-4 upgrade.

Test Plan:
1. DIVU 100/7 -> done at cycle 34, result=14. Repeat with REMU -> result=2. ready=0 for cycles 1..34.
2. DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3). REM -7/2 -> 0xFFFFFFFF(-1). REM 7/-2 -> 1.
3. DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same -> 0. With SEQ_DIVIDER_FAST_SPECIAL_EN, done arrives at cycle 1.
4. Accept 100/7, flush at cycle 10:
   - no done pulse; ready=1 at cycle 11; result unchanged.
   - A new start at cycle 11 is accepted.
5. Accept 100/7, drop rst_n at cycle 20: all outputs go to reset values immediately. After release, 9/3 DIVU -> 3.
6. Hold start high continuously:
   - accepts occur only at cycles 0, 35, 70…
   - done at 34, 69…
   - operands changing during busy are ignored.
